ex_hazard_alu: RTL and testbench

//  Execute-stage core of the 5-stage pipeline: forwarding unit, load-use/branch hazard unit and ALU.

---
 rtl/ex_hazard_alu.sv | 177 +++++++++++++++++
 tb/tb_ex_hazard_alu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_alu.sv
// Execute-stage core: operand forwarding, load-use/branch hazard control and the ALU.
// All outputs are combinational except the registered {N,Z,C,V} status flags.
module ex_hazard_alu #(
  parameter int W  = 32,
  parameter int RW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [4:0]    alu_op,
  input  logic          alu_src,
  input  logic [W-1:0]  id_ex_data_a,
  input  logic [W-1:0]  id_ex_data_b,
  input  logic [W-1:0]  imm,
  input  logic [RW-1:0] id_ex_ra,
  input  logic [RW-1:0] id_ex_rb,
  input  logic          ex_mem_reg_write,
  input  logic [RW-1:0] ex_mem_rd,
  input  logic [W-1:0]  ex_mem_alu,
  input  logic          mem_wb_reg_write,
  input  logic [RW-1:0] mem_wb_rd,
  input  logic [W-1:0]  wb_data,
  input  logic          id_ex_mem_read,
  input  logic [RW-1:0] id_ex_rd,
  input  logic [RW-1:0] if_id_ra,
  input  logic [RW-1:0] if_id_rb,
  input  logic          branch_taken,
  output logic [1:0]    forward_a,
  output logic [1:0]    forward_b,
  output logic [W-1:0]  alu_out,
  output logic          zero,
  output logic          enable_pc,
  output logic          bubble_sel,
  output logic [3:0]    flags_q
);

  localparam int SW = $clog2(W);

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01001;
  localparam logic [4:0] OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_PASB = 5'b01011;
  localparam logic [4:0] OP_PASA = 5'b01100;
  localparam logic [4:0] OP_INC  = 5'b01101;
  localparam logic [4:0] OP_DEC  = 5'b01110;
  localparam logic [4:0] OP_JMP  = 5'b01111;

  logic [W-1:0]  op_a;
  logic [W-1:0]  fwd_b_val;
  logic [W-1:0]  op_b;
  logic [SW-1:0] shamt;
  logic [W-1:0]  add_rhs;
  logic          add_cin;
  logic [W:0]    add_res;
  logic          arith_op;
  logic          flag_n;
  logic          flag_c;
  logic          flag_v;
  logic          load_use;
  logic [3:0]    flags_d;

  // ex_mem is the younger producer, so it outranks mem_wb
  always_comb begin
    forward_a = FWD_IDEX;
    if (ex_mem_reg_write && (ex_mem_rd == id_ex_ra))
      forward_a = FWD_EXMEM;
    else if (mem_wb_reg_write && (mem_wb_rd == id_ex_ra))
      forward_a = FWD_WB;

    forward_b = FWD_IDEX;
    if (!alu_src) begin
      if (ex_mem_reg_write && (ex_mem_rd == id_ex_rb))
        forward_b = FWD_EXMEM;
      else if (mem_wb_reg_write && (mem_wb_rd == id_ex_rb))
        forward_b = FWD_WB;
    end
  end

  always_comb begin
    case (forward_a)
      FWD_EXMEM: op_a = ex_mem_alu;
      FWD_WB:    op_a = wb_data;
      default:   op_a = id_ex_data_a;
    endcase

    case (forward_b)
      FWD_EXMEM: fwd_b_val = ex_mem_alu;
      FWD_WB:    fwd_b_val = wb_data;
      default:   fwd_b_val = id_ex_data_b;
    endcase

    op_b  = alu_src ? imm : fwd_b_val;
    shamt = op_b[SW-1:0];
  end

  // One shared adder: SUB/DEC add the complement plus one, so carry-out is no-borrow
  always_comb begin
    add_rhs  = op_b;
    add_cin  = 1'b0;
    arith_op = 1'b1;
    case (alu_op)
      OP_ADD: begin
        add_rhs = op_b;
        add_cin = 1'b0;
      end
      OP_SUB: begin
        add_rhs = ~op_b;
        add_cin = 1'b1;
      end
      OP_INC: begin
        add_rhs = '0;
        add_cin = 1'b1;
      end
      OP_DEC: begin
        add_rhs = ~({{(W-1){1'b0}}, 1'b1});
        add_cin = 1'b1;
      end
      default: arith_op = 1'b0;
    endcase
    add_res = {1'b0, op_a} + {1'b0, add_rhs} + {{W{1'b0}}, add_cin};
  end

  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: alu_out = add_res[W-1:0];
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_NOT:  alu_out = ~op_a;
      OP_SLL:  alu_out = op_a << shamt;
      OP_SRL:  alu_out = op_a >> shamt;
      OP_SRA:  alu_out = $signed(op_a) >>> shamt;
      OP_SLT:  alu_out = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_out = {{(W-1){1'b0}}, (op_a < op_b)};
      OP_PASB: alu_out = op_b;
      OP_PASA: alu_out = op_a;
      OP_JMP:  alu_out = op_a;
      default: alu_out = '0;
    endcase

    zero = (alu_out == '0) || (alu_op == OP_JMP);
  end

  always_comb begin
    flag_n  = alu_out[W-1];
    flag_c  = arith_op & add_res[W];
    flag_v  = arith_op & (op_a[W-1] == add_rhs[W-1]) & (add_res[W-1] != op_a[W-1]);
    flags_d = {flag_n, zero, flag_c, flag_v};
  end

  // A taken branch flushes the stalled instruction anyway, so it overrides the stall
  always_comb begin
    load_use   = id_ex_mem_read && ((id_ex_rd == if_id_ra) || (id_ex_rd == if_id_rb));
    enable_pc  = branch_taken || !load_use;
    bubble_sel = branch_taken || load_use;
  end

  always_ff @(posedge clock) begin
    if (reset)
      flags_q <= 4'b0000;
    else
      flags_q <= flags_d;
  end

endmodule

// File: tb/tb_ex_hazard_alu.sv
// Directed bench for ex_hazard_alu: forwarding, ALU ops, flag register and hazard outputs.
module tb_ex_hazard_alu;

  localparam int W  = 32;
  localparam int RW = 4;

  logic          clock;
  logic          reset;
  logic [4:0]    alu_op;
  logic          alu_src;
  logic [W-1:0]  id_ex_data_a;
  logic [W-1:0]  id_ex_data_b;
  logic [W-1:0]  imm;
  logic [RW-1:0] id_ex_ra;
  logic [RW-1:0] id_ex_rb;
  logic          ex_mem_reg_write;
  logic [RW-1:0] ex_mem_rd;
  logic [W-1:0]  ex_mem_alu;
  logic          mem_wb_reg_write;
  logic [RW-1:0] mem_wb_rd;
  logic [W-1:0]  wb_data;
  logic          id_ex_mem_read;
  logic [RW-1:0] id_ex_rd;
  logic [RW-1:0] if_id_ra;
  logic [RW-1:0] if_id_rb;
  logic          branch_taken;
  logic [1:0]    forward_a;
  logic [1:0]    forward_b;
  logic [W-1:0]  alu_out;
  logic          zero;
  logic          enable_pc;
  logic          bubble_sel;
  logic [3:0]    flags_q;

  int n_cmp = 0;
  int n_mis = 0;

  ex_hazard_alu #(.W(W), .RW(RW)) dut (
    .clock(clock), .reset(reset), .alu_op(alu_op), .alu_src(alu_src),
    .id_ex_data_a(id_ex_data_a), .id_ex_data_b(id_ex_data_b), .imm(imm),
    .id_ex_ra(id_ex_ra), .id_ex_rb(id_ex_rb),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_alu(ex_mem_alu),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .wb_data(wb_data),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_ra(if_id_ra), .if_id_rb(if_id_rb), .branch_taken(branch_taken),
    .forward_a(forward_a), .forward_b(forward_b), .alu_out(alu_out), .zero(zero),
    .enable_pc(enable_pc), .bubble_sel(bubble_sel), .flags_q(flags_q)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_op = 5'b00000; alu_src = 1'b0;
    id_ex_data_a = '0; id_ex_data_b = '0; imm = '0;
    id_ex_ra = 4'd0; id_ex_rb = 4'd0;
    ex_mem_reg_write = 1'b0; ex_mem_rd = 4'd0; ex_mem_alu = '0;
    mem_wb_reg_write = 1'b0; mem_wb_rd = 4'd0; wb_data = '0;
    id_ex_mem_read = 1'b0; id_ex_rd = 4'd0; if_id_ra = 4'd0; if_id_rb = 4'd0;
    branch_taken = 1'b0;
  endtask

  task automatic alu_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    id_ex_ra = 4'd1; id_ex_rb = 4'd2;
    alu_op = op; id_ex_data_a = a; id_ex_data_b = b;
    #2;
  endtask

  task automatic clock_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    clock_edge();
    check("reset_flags", {28'd0, flags_q}, 32'h0);
    check("idle_enable_pc", {31'd0, enable_pc}, 32'h1);
    check("idle_bubble", {31'd0, bubble_sel}, 32'h0);
    reset = 1'b0;

    // ex_mem and mem_wb both write r3: ex_mem wins
    idle_inputs();
    ex_mem_reg_write = 1'b1; ex_mem_rd = 4'd3; ex_mem_alu = 32'd100;
    mem_wb_reg_write = 1'b1; mem_wb_rd = 4'd3; wb_data = 32'd55;
    id_ex_ra = 4'd3; id_ex_data_a = 32'd9;
    id_ex_rb = 4'd4; id_ex_data_b = 32'd20;
    #2;
    check("fwd_a_exmem", {30'd0, forward_a}, 32'h2);
    check("fwd_b_none", {30'd0, forward_b}, 32'h0);
    check("add_fwd_exmem", alu_out, 32'd120);

    // only mem_wb writes r5, used as B
    idle_inputs();
    mem_wb_reg_write = 1'b1; mem_wb_rd = 4'd5; wb_data = 32'h30;
    id_ex_ra = 4'd1; id_ex_data_a = 32'h10;
    id_ex_rb = 4'd5; id_ex_data_b = 32'h99;
    #2;
    check("fwd_b_wb", {30'd0, forward_b}, 32'h1);
    check("fwd_a_none", {30'd0, forward_a}, 32'h0);
    check("add_fwd_wb", alu_out, 32'h40);
    alu_src = 1'b1; imm = 32'h5;
    #2;
    check("fwd_b_imm_forced", {30'd0, forward_b}, 32'h0);
    check("add_imm", alu_out, 32'h15);

    // mem_wb forwarding for A while ex_mem targets another register
    idle_inputs();
    ex_mem_reg_write = 1'b1; ex_mem_rd = 4'd7; ex_mem_alu = 32'hAAAA;
    mem_wb_reg_write = 1'b1; mem_wb_rd = 4'd0; wb_data = 32'h0F0F;
    id_ex_ra = 4'd0; id_ex_rb = 4'd7; alu_op = 5'b00010;
    #2;
    check("fwd_a_wb_r0", {30'd0, forward_a}, 32'h1);
    check("fwd_b_exmem", {30'd0, forward_b}, 32'h2);
    check("and_fwd", alu_out, 32'h0A0A);

    // SUB equal operands: result 0, no borrow -> C=1
    alu_vec(5'b00001, 32'd7, 32'd7);
    check("sub_eq_out", alu_out, 32'h0);
    check("sub_eq_zero", {31'd0, zero}, 32'h1);
    clock_edge();
    check("sub_eq_flags", {28'd0, flags_q}, 32'h6);

    // ADD signed overflow
    alu_vec(5'b00000, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_out", alu_out, 32'h8000_0000);
    check("add_ovf_zero", {31'd0, zero}, 32'h0);
    clock_edge();
    check("add_ovf_flags", {28'd0, flags_q}, 32'h9);

    alu_vec(5'b01001, 32'hFFFF_FFFF, 32'h1);
    check("slt_neg", alu_out, 32'h1);
    alu_vec(5'b01010, 32'hFFFF_FFFF, 32'h1);
    check("sltu_big", alu_out, 32'h0);
    alu_vec(5'b01000, 32'h8000_0000, 32'd4);
    check("sra_sign", alu_out, 32'hF800_0000);
    alu_vec(5'b00111, 32'h8000_0000, 32'd4);
    check("srl_fill0", alu_out, 32'h0800_0000);
    alu_vec(5'b00110, 32'h1, 32'd31);
    check("sll_top", alu_out, 32'h8000_0000);
    alu_vec(5'b00101, 32'h0000_FFFF, 32'h0);
    check("not_a", alu_out, 32'hFFFF_0000);
    alu_vec(5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("xor", alu_out, 32'h0FF0_0FF0);
    alu_vec(5'b01011, 32'h1234, 32'h5678);
    check("pass_b", alu_out, 32'h5678);

    // JUMP: zero forced even when A is nonzero
    alu_vec(5'b01111, 32'd5, 32'd0);
    check("jump_out", alu_out, 32'd5);
    check("jump_zero", {31'd0, zero}, 32'h1);
    alu_vec(5'b10000, 32'd5, 32'd6);
    check("undef_out", alu_out, 32'h0);
    check("undef_zero", {31'd0, zero}, 32'h1);

    // INC overflow, DEC from zero borrows
    alu_vec(5'b01101, 32'h7FFF_FFFF, 32'h0);
    check("inc_out", alu_out, 32'h8000_0000);
    clock_edge();
    check("inc_flags", {28'd0, flags_q}, 32'h9);
    alu_vec(5'b01110, 32'h0, 32'h0);
    check("dec_out", alu_out, 32'hFFFF_FFFF);
    clock_edge();
    check("dec_flags", {28'd0, flags_q}, 32'h8);

    // ADD with unsigned carry out, result zero
    alu_vec(5'b00000, 32'hFFFF_FFFF, 32'h1);
    clock_edge();
    check("add_carry_flags", {28'd0, flags_q}, 32'h6);

    // logic op leaves C/V clear
    alu_vec(5'b00011, 32'h8000_0000, 32'h1);
    clock_edge();
    check("or_flags", {28'd0, flags_q}, 32'h8);

    // load-use stall, then branch overrides
    idle_inputs();
    id_ex_mem_read = 1'b1; id_ex_rd = 4'd2; if_id_ra = 4'd6; if_id_rb = 4'd2;
    #2;
    check("lu_enable_pc", {31'd0, enable_pc}, 32'h0);
    check("lu_bubble", {31'd0, bubble_sel}, 32'h1);
    branch_taken = 1'b1;
    #2;
    check("lu_br_enable_pc", {31'd0, enable_pc}, 32'h1);
    check("lu_br_bubble", {31'd0, bubble_sel}, 32'h1);
    idle_inputs();
    id_ex_mem_read = 1'b1; id_ex_rd = 4'd9; if_id_ra = 4'd9; if_id_rb = 4'd1;
    #2;
    check("lu_ra_enable_pc", {31'd0, enable_pc}, 32'h0);
    if_id_ra = 4'd8;
    #2;
    check("lu_miss_enable_pc", {31'd0, enable_pc}, 32'h1);
    check("lu_miss_bubble", {31'd0, bubble_sel}, 32'h0);
    id_ex_mem_read = 1'b0; if_id_ra = 4'd9;
    #2;
    check("no_load_bubble", {31'd0, bubble_sel}, 32'h0);
    branch_taken = 1'b1;
    #2;
    check("br_only_bubble", {31'd0, bubble_sel}, 32'h1);
    check("br_only_enable_pc", {31'd0, enable_pc}, 32'h1);

    // reset during a carrying ADD: flags clear, ALU output unaffected
    alu_vec(5'b00110, 32'h1, 32'd31);
    clock_edge();
    check("pre_reset_flags", {28'd0, flags_q}, 32'h8);
    alu_vec(5'b00000, 32'hFFFF_FFFF, 32'h2);
    reset = 1'b1;
    clock_edge();
    check("reset_wins_flags", {28'd0, flags_q}, 32'h0);
    check("reset_alu_out", alu_out, 32'h1);
    reset = 1'b0;
    clock_edge();
    check("post_reset_flags", {28'd0, flags_q}, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
